pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage of the openMIPS pipeline. It holds the instruction fetch address, drives the instruction-memory chip enable, and advances the PC by one instruction per accepted fetch. Compared with a plain incrementing PC, it adds:
- a configurable reset vector and widths;
- pipeline stall and memory back-pressure;
- branch redirect with a one-entry pending-redirect buffer;
- exception flush with fixed priority;
- target alignment checking.

## Interface
Parameters:
- ADDR_W, 32, width of the PC and all target buses.
- INST_BYTES, 4, bytes per instruction; PC increment; power of two, at least 1.
- RESET_VECTOR, 32'h00000000, first fetch address after reset; must be INST_BYTES-aligned.
- STALL_W, 6, width of the pipeline stall vector; only bit 0 (fetch stage) is used by this block.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- stall, input, STALL_W, pipeline stall vector; stall[0]=1 freezes the PC.
- if_ready, input, 1, instruction memory accepts the current fetch this cycle.
- branch_flag, input, 1, redirect request from decode/execute.
- branch_target, input, ADDR_W, redirect address.
- flush, input, 1, exception/ERET flush request.
- flush_pc, input, ADDR_W, handler or return address.
- ce, output, 1, instruction-memory chip enable.
- pc, output, ADDR_W, current fetch address.
- redirect_pending, output, 1, a captured branch is waiting to be applied.
- misalign, output, 1, one-cycle pulse when an applied target had nonzero low bits.

## Operation
- States: OFF and RUN.
- OFF: ce=0, pc=RESET_VECTOR. Entered asynchronously while rst=0. Moves to RUN on the first rising edge with rst=1.
- RUN: ce=1. Stays in RUN until reset.
- Advance condition: adv = RUN & ~stall[0] & if_ready.
- Per-edge update in RUN, highest priority first:
  1. flush=1: pc <= aligned(flush_pc); pending cleared. Applies regardless of stall and if_ready.
  2. branch_flag=1 & adv: pc <= aligned(branch_target); pending cleared.
  3. branch_flag=1 & ~adv: pending captured (pend_target <= branch_target, pending set); pc holds. A newer branch overwrites an older pending target.
  4. pending & adv: pc <= aligned(pend_target); pending cleared.
  5. adv: pc <= pc + INST_BYTES, modulo 2^ADDR_W. 32'hFFFFFFFC wraps to 32'h00000000.
  6. Otherwise pc holds.
- aligned(x): x with the low log2(INST_BYTES) bits forced to 0.
- misalign is registered. It is 1 for the cycle after any applied flush, branch, or pending target whose low bits were nonzero, and 0 otherwise. A captured-but-unapplied target does not raise misalign until it is applied.
- In OFF, branch_flag and flush are ignored and nothing is captured.
- redirect_pending mirrors the pending register.

## Timing
- Reset values: ce=0, pc=RESET_VECTOR, redirect_pending=0, misalign=0. Internal pending target=0.
- Reset release: ce=1 after the first edge with rst=1. pc stays at RESET_VECTOR for that edge. The first increment occurs on the next edge with adv=1.
- Redirect latency: a request sampled at edge n appears on pc after edge n (one cycle).
- Pending redirect: applied on the first edge with adv=1. The same edge clears redirect_pending.
- Simultaneous branch and flush: flush wins; the branch is discarded, not captured.
- Flush while pending: pending is cleared, pc <= flush_pc.
- Branch while pending and adv=1: the new branch wins, and the old pending target is discarded.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). Any pending redirect is lost.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/increment: hold rst=0, then release with stall=0 and if_ready=1. Expect ce 0→1 one edge after release; pc sequence 0x0, 0x0, 0x4, 0x8.
- Stall/back-pressure: pulse stall[0]=1 for 3 cycles at pc=0x10, then if_ready=0 for 2 cycles. Expect pc to hold 0x10 for 5 cycles, then 0x14.
- Pending branch: at pc=0x20 with stall[0]=1, assert branch_flag with target 0x100 for one cycle. Expect redirect_pending=1 and pc held at 0x20. After releasing the stall: pc=0x100, redirect_pending=0, then 0x104.
- Priority: assert flush (flush_pc=0x80000180) and branch_flag (target 0x400) in the same cycle while stalled. Expect pc=0x80000180 next cycle and redirect_pending=0.
- Misalign/wrap: branch to 0x203. Expect pc=0x200 and a one-cycle misalign pulse. Branch to 0xFFFFFFFC. Expect pc 0xFFFFFFFC, then 0x00000000.
- Async reset mid-run: assert rst=0 between edges while pending=1. Expect ce=0, pc=RESET_VECTOR, and redirect_pending=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen - program-counter generator for the openMIPS fetch stage.
//
// Holds the instruction fetch address, drives the instruction-memory chip
// enable and advances by one instruction per accepted fetch. Supports
// pipeline stall, memory back-pressure, branch redirects with a one-entry
// pending buffer, exception flush and target alignment checking.
//
// Parameters:
//   ADDR_W       width of the PC and all target buses
//   INST_BYTES   bytes per instruction (power of two, >= 1)
//   RESET_VECTOR first fetch address after reset (INST_BYTES-aligned)
//   STALL_W      width of the pipeline stall vector (only bit 0 used)
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   stall            pipeline stall vector; stall[0] freezes the PC
//   if_ready         instruction memory accepts the current fetch
//   branch_flag      redirect request
//   branch_target    redirect address
//   flush            exception/ERET flush request
//   flush_pc         handler or return address
//   ce               instruction-memory chip enable
//   pc               current fetch address
//   redirect_pending a captured branch is waiting to be applied
//   misalign         one-cycle pulse when an applied target had low bits set
module pc_gen #(
  parameter int                 ADDR_W       = 32,
  parameter int                 INST_BYTES   = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int                 STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               if_ready,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  output logic               ce,
  output logic [ADDR_W-1:0]  pc,
  output logic               redirect_pending,
  output logic               misalign
);

  // Low-bit mask covering the byte offset inside one instruction.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INST_BYTES);

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pend_target;
  logic               adv;

  // Only the fetch-stage stall bit matters here; the rest of the vector
  // belongs to later pipeline stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  // A fetch is accepted when running, not stalled, and memory is ready.
  assign adv = (state == RUN) && !stall[0] && if_ready;

  // Single sequential block: OFF waits one edge after reset release, RUN
  // applies the redirect priority chain (flush, branch, pending, increment).
  // misalign defaults low every edge so it only ever pulses for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= OFF;
      ce               <= 1'b0;
      pc               <= RESET_VECTOR;
      redirect_pending <= 1'b0;
      pend_target      <= '0;
      misalign         <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        OFF: begin
          // Redirect requests are ignored until the PC is running.
          state <= RUN;
          ce    <= 1'b1;
        end
        RUN: begin
          ce <= 1'b1;
          if (flush) begin
            pc               <= flush_pc & ~LOW_MASK;
            misalign         <= |(flush_pc & LOW_MASK);
            redirect_pending <= 1'b0;
          end else if (branch_flag && adv) begin
            pc               <= branch_target & ~LOW_MASK;
            misalign         <= |(branch_target & LOW_MASK);
            redirect_pending <= 1'b0;
          end else if (branch_flag) begin
            // Fetch blocked: hold the target until a fetch is accepted.
            // A newer branch simply overwrites the older one.
            pend_target      <= branch_target;
            redirect_pending <= 1'b1;
          end else if (redirect_pending && adv) begin
            pc               <= pend_target & ~LOW_MASK;
            misalign         <= |(pend_target & LOW_MASK);
            redirect_pending <= 1'b0;
          end else if (adv) begin
            pc <= pc + INC;
          end
        end
        default: begin
          state <= OFF;
          ce    <= 1'b0;
        end
      endcase
    end
  end

endmodule
